// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: byte-addressed instruction memory with a one-deep
// fetch response register and a byte-wide load port.
//
// Ports
//   clk, nreset          clock, asynchronous active-low reset
//   req_valid/ready/addr fetch request (req_ready is combinational)
//   rsp_valid/ready      response handshake
//   rsp_data             fetched 32-bit word (0 on fault)
//   rsp_fault            bit0 misaligned, bit1 out of range
//   load_en/addr/byte    byte write into memory; has priority over fetch
module imem_fetch_unit #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_BYTES = 256,
  parameter bit          BIG_ENDIAN  = 1'b1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [1:0]        rsp_fault,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_byte
);

  localparam int unsigned       IDX_W          = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = ADDR_W'(DEPTH_BYTES - 4);
  localparam logic [ADDR_W-1:0] DEPTH_ADDR     = ADDR_W'(DEPTH_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    LOAD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [1:0]  rsp_fault_q, rsp_fault_d;

  logic [7:0]  mem_q [DEPTH_BYTES];

  logic             accept_c;
  logic             handshake_c;
  logic             load_we_c;
  logic [IDX_W-1:0] rd_idx_c;
  logic [IDX_W-1:0] wr_idx_c;
  logic [7:0]       rd_byte_c [4];
  logic [31:0]      fetch_word_c;
  logic [1:0]       fetch_fault_c;

  // Loads block fetch acceptance; a held response frees the slot when consumed.
  assign req_ready   = !load_en && (!rsp_valid_q || rsp_ready);
  assign accept_c    = req_valid && req_ready;
  assign handshake_c = rsp_valid_q && rsp_ready;

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_fault = rsp_fault_q;

  // Out-of-range test is done at full address width so large addresses never alias.
  assign fetch_fault_c = {req_addr > LAST_WORD_ADDR, req_addr[1:0] != 2'b00};
  assign rd_idx_c      = req_addr[IDX_W-1:0];

  // Gather the four bytes of the requested word and order them by endianness.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      rd_byte_c[i] = mem_q[IDX_W'(rd_idx_c + IDX_W'(i))];
    end
    if (BIG_ENDIAN) begin
      fetch_word_c = {rd_byte_c[0], rd_byte_c[1], rd_byte_c[2], rd_byte_c[3]};
    end else begin
      fetch_word_c = {rd_byte_c[3], rd_byte_c[2], rd_byte_c[1], rd_byte_c[0]};
    end
  end

  // Next-state and response register update.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;

    if (accept_c) begin
      rsp_valid_d = 1'b1;
      rsp_fault_d = fetch_fault_c;
      rsp_data_d  = (fetch_fault_c != 2'b00) ? 32'h0 : fetch_word_c;
    end else if (handshake_c) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = RESP;
        end else if (load_en) begin
          state_d = LOAD;
        end
      end
      RESP: begin
        if (handshake_c && !accept_c) begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        // req_ready rises in the same cycle load_en falls, so a fetch may land here.
        if (!load_en) begin
          state_d = accept_c ? RESP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_fault_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  // Byte storage; not reset so program contents survive a core reset.
  assign load_we_c = load_en && (load_addr < DEPTH_ADDR);
  assign wr_idx_c  = load_addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (load_we_c) begin
      mem_q[wr_idx_c] <= load_byte;
    end
  end

endmodule
